// File: rtl/io_timer.sv
// io_timer: two-channel memory-mapped down-counting timer/counter on the CPU I/O bus
module io_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cs,
    input  logic             ioread,
    input  logic             iowrite,
    input  logic [2:0]       addr,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] rdata,
    input  logic             pulse0,
    input  logic             pulse1,
    output logic             cout0,
    output logic             cout1
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state [2];
    logic [1:0]       mode  [2];
    logic [CNT_W-1:0] init  [2];
    logic [CNT_W-1:0] count [2];
    logic [1:0]       done, cout, s1, s2, s3;
    logic [1:0]       sel, tick, mode_wr, init_wr, stat_rd;
    logic             wr, rd, ch;

    // Bus decode: addr[1] picks the channel, addr[2] picks mode/status vs init/count
    always_comb begin
        wr      = cs & iowrite;
        rd      = cs & ioread;
        ch      = addr[1];
        sel     = {addr[1], ~addr[1]};
        mode_wr = (wr && !addr[2]) ? sel : 2'b00;
        init_wr = (wr &&  addr[2]) ? sel : 2'b00;
        stat_rd = (rd && !addr[2]) ? sel : 2'b00;
        tick    = ~{mode[1][0], mode[0][0]} | (s2 & ~s3);
        rdata   = !rd ? '0 : addr[2] ? count[ch] : {state[ch] == RUN, {(CNT_W-2){1'b0}}, done[ch]};
    end

    assign cout0 = cout[0];
    assign cout1 = cout[1];

    // Two-flop synchronizer plus edge register for the external event inputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 2'b00;
            s2 <= 2'b00;
            s3 <= 2'b00;
        end else begin
            s1 <= {pulse1, pulse0};
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Per-channel IDLE/RUN machine; bus writes take priority over ticks, terminal set beats read clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                state[i] <= IDLE;
                mode[i]  <= 2'b00;
                init[i]  <= '0;
                count[i] <= '0;
            end
            done <= 2'b00;
            cout <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                cout[i] <= 1'b0;
                if (stat_rd[i])
                    done[i] <= 1'b0;
                if (mode_wr[i]) begin
                    mode[i]  <= wdata[1:0];
                    state[i] <= IDLE;
                    done[i]  <= 1'b0;
                end else if (init_wr[i]) begin
                    init[i]  <= wdata;
                    count[i] <= wdata;
                    state[i] <= (wdata != '0) ? RUN : IDLE;
                    if (wdata != '0)
                        done[i] <= 1'b0;
                end else if (state[i] == RUN && tick[i]) begin
                    if (count[i] != CNT_W'(1)) begin
                        count[i] <= count[i] - 1'b1;
                    end else begin
                        done[i]  <= 1'b1;
                        cout[i]  <= 1'b1;
                        count[i] <= mode[i][1] ? init[i] : '0;
                        state[i] <= mode[i][1] ? RUN : IDLE;
                    end
                end
            end
        end
    end
endmodule
